// File: rtl/v_clkgate_ctrl.sv
// Clock-enable controller for the vector coprocessor's gated functional units.
// Optional per-unit enabled-cycle statistics are built only when VCG_STATS_EN is defined.
module v_clkgate_ctrl #(
    parameter int NUM_UNITS   = 5,
    parameter int HOLD_CYCLES = 4,
    parameter int HOLD_W      = 4
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [NUM_UNITS-1:0] op_active,
    input  logic [NUM_UNITS-1:0] unit_done,
    input  logic                 force_on,
    output logic [NUM_UNITS-1:0] clk_en,
    output logic [NUM_UNITS-1:0] unit_busy,
    output logic                 all_idle,
    input  logic [3:0]           stat_sel,
    input  logic                 stat_clr,
    output logic [31:0]          stat_count
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ON   = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HCNT_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};

    state_t                 r_state      [NUM_UNITS];
    state_t                 w_state_nx   [NUM_UNITS];
    logic   [HOLD_W-1:0]    r_hcnt       [NUM_UNITS];
    logic   [HOLD_W-1:0]    w_hcnt_nx    [NUM_UNITS];
    logic   [NUM_UNITS-1:0] r_done_seen;
    logic   [NUM_UNITS-1:0] w_done_seen_nx;
    logic   [NUM_UNITS-1:0] w_busy;

    // Per-unit FSM state register; reset discards all in-flight state.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                r_state[i] <= ST_OFF;
                r_hcnt[i]  <= '0;
            end
            r_done_seen <= '0;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                r_state[i] <= w_state_nx[i];
                r_hcnt[i]  <= w_hcnt_nx[i];
            end
            r_done_seen <= w_done_seen_nx;
        end
    end

    // Per-unit next-state logic: re-activation in HOLD wins over expiry.
    always_comb begin
        w_done_seen_nx = r_done_seen;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_state_nx[i] = r_state[i];
            w_hcnt_nx[i]  = r_hcnt[i];
            case (r_state[i])
                ST_OFF: begin
                    if (op_active[i]) begin
                        w_state_nx[i]     = ST_ON;
                        w_done_seen_nx[i] = 1'b0;
                    end else begin
                        w_state_nx[i] = ST_OFF;
                    end
                end
                ST_ON: begin
                    if (!op_active[i] && (r_done_seen[i] || unit_done[i])) begin
                        w_done_seen_nx[i] = 1'b0;
                        if (HOLD_CYCLES > 0) begin
                            w_state_nx[i] = ST_HOLD;
                            w_hcnt_nx[i]  = HOLD_LOAD;
                        end else begin
                            w_state_nx[i] = ST_OFF;
                            w_hcnt_nx[i]  = '0;
                        end
                    end else begin
                        w_done_seen_nx[i] = r_done_seen[i] | unit_done[i];
                    end
                end
                ST_HOLD: begin
                    if (op_active[i]) begin
                        w_state_nx[i]     = ST_ON;
                        w_done_seen_nx[i] = 1'b0;
                        w_hcnt_nx[i]      = '0;
                    end else if (r_hcnt[i] <= HCNT_ONE) begin
                        w_state_nx[i] = ST_OFF;
                        w_hcnt_nx[i]  = '0;
                    end else begin
                        w_hcnt_nx[i] = r_hcnt[i] - HCNT_ONE;
                    end
                end
                default: begin
                    w_state_nx[i]     = ST_OFF;
                    w_hcnt_nx[i]      = '0;
                    w_done_seen_nx[i] = 1'b0;
                end
            endcase
        end
    end

    // Busy flags decoded straight from state.
    always_comb begin
        w_busy = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_busy[i] = (r_state[i] != ST_OFF);
        end
    end

    // Zero-latency CE: every term is clk-synchronous, safe for a sync-CE BUFGCE.
    assign clk_en    = w_busy | op_active | {NUM_UNITS{force_on}} | {NUM_UNITS{~nrst}};
    assign unit_busy = w_busy;
    assign all_idle  = ~(|w_busy) & ~(|op_active);

`ifdef VCG_STATS_EN
    logic [31:0] r_cnt [NUM_UNITS];
    logic [31:0] w_sel_cnt;
    logic [31:0] r_stat_count;

    // Saturating enabled-cycle counters; clear beats increment.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                r_cnt[i] <= 32'd0;
            end
        end else if (stat_clr) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                r_cnt[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (clk_en[i] && (r_cnt[i] != 32'hFFFF_FFFF)) begin
                    r_cnt[i] <= r_cnt[i] + 32'd1;
                end else begin
                    r_cnt[i] <= r_cnt[i];
                end
            end
        end
    end

    // Readback mux; out-of-range selects match no unit and read zero.
    always_comb begin
        w_sel_cnt = 32'd0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_sel_cnt = w_sel_cnt | (r_cnt[i] & {32{stat_sel == 4'(i)}});
        end
    end

    // Registered readback port.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_stat_count <= 32'd0;
        end else begin
            r_stat_count <= w_sel_cnt;
        end
    end

    assign stat_count = r_stat_count;
`else
    logic w_unused_stat;

    assign w_unused_stat = ^{stat_sel, stat_clr};
    assign stat_count    = 32'd0;
`endif

endmodule
